// File: rtl/bin2bcd_pkg.sv
// Shared state encoding, digit constants and small constant helpers for the
// binary-to-BCD conversion sequencer.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } seq_state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    // Digit-index width for the default four-digit display.
    localparam int DIGIT_IDX_W = idx_width(4);

endpackage

// File: rtl/bin2bcd_sequencer.sv
// Converts a binary value to packed BCD by issuing one divide-by-10 per digit on an
// external shared divider. Optional LEADING_ZERO_BLANK_EN adds the blank[] output.
module bin2bcd_sequencer
    import bin2bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int W      = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [W-1:0]              value,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      overflow,
    output logic                      div_start,
    output logic [W-1:0]              div_dividend,
    input  logic [W-5:0]              div_quotient,
    input  logic [W-1:0]              div_remainder,
    input  logic                      div_done
`ifdef LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]         blank
`endif
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int IDX_W = idx_width(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [63:0] MAX_VALUE = 64'(pow10(DIGITS) - 1);

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [W-1:0]      dividend_q, dividend_d;
    logic [BCD_W-1:0]  digits_q, digits_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              range_ovf_q, range_ovf_d;
    logic              arm_q;
    logic [BCD_W-1:0]  digits_cap;
    logic [BCD_W-1:0]  nines;
    logic              capture;
    logic              last_capture;
    logic              final_ovf;
    logic              unused_rem;

    assign unused_rem = ^div_remainder[W-1:DIGIT_W];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nines
            assign nines[gi*DIGIT_W +: DIGIT_W] = BCD_NINE;
        end
    endgenerate

    always_comb begin
        digits_cap = digits_q;
        digits_cap[int'(idx_q)*DIGIT_W +: DIGIT_W] = div_remainder[DIGIT_W-1:0];
    end

    // The quotient bus is narrower than the dividend, so the first quotient of an
    // out-of-range value can wrap; the range check on the latched value covers that.
    assign final_ovf    = range_ovf_q | (|div_quotient);
    assign capture      = (state_q == WAIT) && arm_q && div_done;
    assign last_capture = capture && (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dividend_d  = dividend_q;
        digits_d    = digits_q;
        range_ovf_d = range_ovf_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dividend_d  = value;
                    digits_d    = '0;
                    idx_d       = '0;
                    range_ovf_d = 64'(value) > MAX_VALUE;
                    state_d     = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (capture) begin
                    digits_d   = digits_cap;
                    dividend_d = {{DIGIT_W{1'b0}}, div_quotient};
                    if (idx_q == LAST_IDX) begin
                        bcd_d   = final_ovf ? nines : digits_cap;
                        ovf_d   = final_ovf;
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // arm_q masks the first WAIT cycle, when div_done may still be stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dividend_q  <= '0;
            digits_q    <= '0;
            range_ovf_q <= 1'b0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            arm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dividend_q  <= dividend_d;
            digits_q    <= digits_d;
            range_ovf_q <= range_ovf_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            arm_q       <= (state_q == WAIT);
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FINISH);
    assign div_start    = (state_q == ISSUE);
    assign div_dividend = dividend_q;
    assign bcd          = bcd_q;
    assign overflow     = ovf_q;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_cap;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_ones
                assign blank_cap[gi] = 1'b0;
            end else begin : g_upper
                assign blank_cap[gi] = ~|digits_cap[BCD_W-1:gi*DIGIT_W];
            end
        end
    endgenerate

    assign blank_d = last_capture ? (final_ovf ? '0 : blank_cap) : blank_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_sequencer.sv
// Self-checking bench: behavioural divide-by-10 with configurable latency and a
// scoreboard of expected conversion results.
`timescale 1ns/1ps
module tb_bin2bcd_sequencer;

    localparam int DIGITS = 4;
    localparam int W      = 14;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic                ovf;
        logic [DIGITS-1:0]   blank;
        int                  lat;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [W-1:0]        value;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                overflow;
    logic                div_start;
    logic [W-1:0]        div_dividend;
    logic [W-5:0]        div_quotient;
    logic [W-1:0]        div_remainder;
    logic                div_done;
`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]   blank;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   div_lat  = 3;
    int   cnt      = 0;
    int   ds_count = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bin2bcd_sequencer #(.DIGITS(DIGITS), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .value        (value),
        .busy         (busy),
        .done         (done),
        .bcd          (bcd),
        .overflow     (overflow),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_done     (div_done)
`ifdef LEADING_ZERO_BLANK_EN
        ,
        .blank        (blank)
`endif
    );

    // Divider model: done drops on the edge sampling div_start and rises so that it is
    // visible div_lat cycles after the div_start cycle; quotient bus is W-4 bits wide.
    always @(posedge clk) begin
        if (reset) begin
            div_done <= 1'b0;
            cnt      <= 0;
        end else if (div_start) begin
            div_done      <= 1'b0;
            cnt           <= div_lat - 1;
            div_quotient  <= (W-4)'(div_dividend / 10);
            div_remainder <= {(W-4)'($urandom), 4'(div_dividend % 10)};
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) div_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (div_start === 1'b1) ds_count++;
    end

    function automatic exp_t model(input int v, input int lat);
        exp_t e;
        int   t;
        t     = v;
        e.ovf = (v > 9999);
        e.bcd = '0;
        for (int k = 0; k < DIGITS; k++) begin
            e.bcd[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        if (e.ovf) e.bcd = 16'h9999;
        e.blank = '0;
        for (int k = 1; k < DIGITS; k++) begin
            e.blank[k] = ((e.bcd >> (4*k)) == '0) && !e.ovf;
        end
        e.lat = 1 + DIGITS * (1 + lat) + 1;
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one conversion and returns the start-to-done cycle count (inclusive), or -1.
    task automatic run_conv(input logic [W-1:0] v, input bit hold, input bit scramble,
                            output int lat_obs);
        int c;
        value = v;
        start = 1'b1;
        sb.push_back(model(int'(v), div_lat));
        tick;
        c = 1;
        if (!hold) start = 1'b0;
        while (done !== 1'b1 && c < 1000) begin
            if (scramble) value = W'($urandom);
            tick;
            c++;
        end
        lat_obs = (done === 1'b1) ? c + 1 : -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        tick;
        tick;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (bcd !== '0) begin failures++; $display("FAIL reset_bcd: got %h want 0000", bcd); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL reset_div_start: got %b want 0", div_start); end
        checks++; if (div_dividend !== '0) begin failures++; $display("FAIL reset_dividend: got %0d want 0", div_dividend); end
`ifdef LEADING_ZERO_BLANK_EN
        checks++; if (blank !== '0) begin failures++; $display("FAIL reset_blank: got %b want 0000", blank); end
`endif
        reset = 1'b0;
        tick;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_values;
        logic [W-1:0] vals [5];
        vals = '{14'd34, 14'd9999, 14'd0, 14'd12345, 14'd7};
        for (int i = 0; i < 5; i++) begin
            int   lat;
            exp_t e;
            run_conv(vals[i], 1'b0, 1'b0, lat);
            e = sb.pop_front();
            $display("conv value=%0d bcd=%h ovf=%b latency=%0d", vals[i], bcd, overflow, lat);
            checks++; if (lat !== e.lat) begin failures++; $display("FAIL values_latency v=%0d: got %0d want %0d", vals[i], lat, e.lat); end
            checks++; if (bcd !== e.bcd) begin failures++; $display("FAIL values_bcd v=%0d: got %h want %h", vals[i], bcd, e.bcd); end
            checks++; if (overflow !== e.ovf) begin failures++; $display("FAIL values_ovf v=%0d: got %b want %b", vals[i], overflow, e.ovf); end
`ifdef LEADING_ZERO_BLANK_EN
            checks++; if (blank !== e.blank) begin failures++; $display("FAIL values_blank v=%0d: got %b want %b", vals[i], blank, e.blank); end
`endif
            tick;
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL values_post_done v=%0d: busy=%b done=%b want 0 0", vals[i], busy, done); end
        end
    endtask

    task automatic test_back_to_back;
        int   lat;
        exp_t e;
        ds_count = 0;
        run_conv(14'd1234, 1'b1, 1'b1, lat);
        e = sb.pop_front();
        $display("conv value=1234 held-start bcd=%h div_starts=%0d latency=%0d", bcd, ds_count, lat);
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL b2b_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (bcd !== e.bcd) begin failures++; $display("FAIL b2b_bcd: got %h want %h", bcd, e.bcd); end
        checks++; if (ds_count !== DIGITS) begin failures++; $display("FAIL b2b_div_starts: got %0d want %0d", ds_count, DIGITS); end
        value = 14'd905;
        tick;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_finish_start_ignored: busy=%b want 0", busy); end
        ds_count = 0;
        run_conv(14'd905, 1'b0, 1'b0, lat);
        e = sb.pop_front();
        $display("conv value=905 accepted-after-finish bcd=%h latency=%0d", bcd, lat);
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL b2b2_latency: got %0d want %0d", lat, e.lat); end
        checks++; if (bcd !== e.bcd) begin failures++; $display("FAIL b2b2_bcd: got %h want %h", bcd, e.bcd); end
        checks++; if (ds_count !== DIGITS) begin failures++; $display("FAIL b2b2_div_starts: got %0d want %0d", ds_count, DIGITS); end
        tick;
    endtask

    task automatic test_reset_mid;
        int   c;
        int   seen;
        int   lat;
        exp_t e;
        ds_count = 0;
        value = 14'd5678;
        start = 1'b1;
        sb.push_back(model(5678, div_lat));
        tick;
        start = 1'b0;
        c = 0;
        while (!(ds_count == 3 && div_start === 1'b0) && c < 200) begin
            tick;
            c++;
        end
        checks++; if (c >= 200) begin failures++; $display("FAIL reset_mid_reach_wait3: got timeout want third WAIT"); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        sb.delete();
        $display("reset mid-conversion busy=%b div_start=%b bcd=%h", busy, div_start, bcd);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
        checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL reset_mid_div_start: got %b want 0", div_start); end
        checks++; if (bcd !== '0) begin failures++; $display("FAIL reset_mid_bcd: got %h want 0000", bcd); end
        checks++; if (overflow !== 1'b0 || div_dividend !== '0) begin failures++; $display("FAIL reset_mid_clear: ovf=%b dividend=%0d want 0 0", overflow, div_dividend); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen++;
            tick;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL reset_mid_no_done: got %0d done pulses want 0", seen); end
        run_conv(14'd56, 1'b0, 1'b0, lat);
        e = sb.pop_front();
        $display("conv value=56 after reset bcd=%h latency=%0d", bcd, lat);
        checks++; if (bcd !== e.bcd) begin failures++; $display("FAIL reset_mid_next_bcd: got %h want %h", bcd, e.bcd); end
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL reset_mid_next_latency: got %0d want %0d", lat, e.lat); end
        tick;
    endtask

    task automatic test_latency;
        int lats [2];
        lats = '{2, 10};
        for (int i = 0; i < 2; i++) begin
            int   lat;
            exp_t e;
            div_lat = lats[i];
            run_conv(14'd8021, 1'b0, 1'b0, lat);
            e = sb.pop_front();
            $display("conv value=8021 L=%0d bcd=%h latency=%0d", lats[i], bcd, lat);
            checks++; if (bcd !== e.bcd) begin failures++; $display("FAIL latency_bcd L=%0d: got %h want %h", lats[i], bcd, e.bcd); end
            checks++; if (lat !== e.lat) begin failures++; $display("FAIL latency_cycles L=%0d: got %0d want %0d", lats[i], lat, e.lat); end
            tick;
        end
        div_lat = 3;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        test_reset;
        test_values;
        test_back_to_back;
        test_reset_mid;
        test_latency;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
